axi_fetch_unit: RTL and testbench
=================================

// Module: axi_fetch_unit
// PURPOSE
//  Instruction fetch front end. Issues line-sized AXI INCR read bursts starting at the PC.
//  Splits each returned beat into 32-bit instructions and buffers them in a FIFO.
//  Delivers one instruction per cycle, tagged with its PC, to decode over valid/ready.
//  Sits between the AXI master read channels in top and the decode stage; supports redirects.
// PARAMETERS
//  ID_WIDTH     13  AXI ID width; arid is always 0
//  ADDR_WIDTH   64  address / PC width
//  DATA_WIDTH   64  AXI data width; must be a multiple of 32
//  BURST_BEATS  8   beats per burst; LINE_BYTES = BURST_BEATS*DATA_WIDTH/8 (default 64 B)
//  FIFO_DEPTH   32  instruction FIFO entries; power of 2, >= WPL = LINE_BYTES/4
// PORTS
//  clk             in   1           clock
//  reset           in   1           synchronous, active-high reset
//  entry           in   ADDR_WIDTH  PC loaded on reset
//  redirect_valid  in   1           restart fetch at redirect_pc
//  redirect_pc     in   ADDR_WIDTH  new PC; bits [1:0] ignored
//  inst_valid      out  1           FIFO head valid
//  inst_ready      in   1           decode accepts the head
//  inst            out  32          instruction word
//  inst_pc         out  ADDR_WIDTH  byte address of inst
//  fetch_error     out  1           sticky; a read returned rresp!=0
//  m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid} out; m_axi_arready in
//  m_axi_r{id,data,resp,last,valid} in; m_axi_rready out
// BEHAVIOUR
//  Reset values:
//   - pc<=entry&~3; FIFO empty; inst_valid=0; fetch_error=0; arvalid=0; rready=0; state IDLE.
//   - arlen=BURST_BEATS-1; arsize=log2(DATA_WIDTH/8); arburst=2'b01; arlock=0; arcache=0; arprot=3'b110.
//  States:
//   - IDLE->ADDR when FIFO free slots >= WPL.
//   - ADDR: arvalid=1; araddr = pc with the low log2(LINE_BYTES) bits cleared, held stable.
//     On arready, go to DATA, or to DRAIN if a redirect arrived during ADDR.
//   - DATA: rready=1. On each beat, word k is taken from bits [32k+31:32k] and pushed low word first.
//     Words below pc's offset in the first beat are skipped. On rlast: pc<=line base+LINE_BYTES; go IDLE.
//   - DRAIN: rready=1; all beats discarded; on rlast go IDLE.
//   - ERR: no requests issued; leaves only on redirect (->IDLE).
//  Read errors: a beat with rresp!=0 sets fetch_error. It and all remaining beats of that burst
//   are discarded, and the state goes to ERR after rlast.
//  Flow control:
//   - Free-slot check is made at issue time; pops only add room, so a push never finds the FIFO full.
//   - Push and pop in the same cycle are legal.
//   - Empty FIFO -> inst_valid=0. Registered output: first instruction appears 1 cycle after its beat.
//  Redirect (highest priority):
//   - Same cycle: FIFO flushed, inst_valid=0 next cycle, pc<=redirect_pc&~3, fetch_error cleared.
//   - In DATA: go DRAIN. In ADDR: arvalid and araddr are held until the handshake, then DRAIN.
//   - Same cycle as rlast: go IDLE (burst complete).
//  PC arithmetic wraps modulo 2^ADDR_WIDTH.
//  Reset mid-burst returns to IDLE immediately; the interconnect is reset together with this block.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output ports perf_bursts, perf_insts and perf_stall_cycles (64 b each).
//   - perf_bursts counts AR handshakes.
//   - perf_insts counts inst_valid&&inst_ready.
//   - perf_stall_cycles counts cycles with inst_ready=1 and inst_valid=0.
//   - All counters clear on reset and wrap.
//  FETCH_PERF_EN undefined: the ports and counters do not exist.
// TESTING
//  1. entry=0x1000, memory word i = i, inst_ready=1 -> araddr=0x1000, arlen=7;
//     insts 0..15 with inst_pc 0x1000..0x103C in order; next araddr=0x1040.
//  2. entry=0x1008 -> araddr=0x1000; first inst_pc=0x1008; 14 words from the first line.
//  3. inst_ready=0 with FIFO_DEPTH=32 -> exactly 2 bursts issued, then arvalid stays 0
//     until at least 16 entries are popped.
//  4. redirect_valid with redirect_pc=0x2004 during beat 3 -> remaining beats dropped;
//     next araddr=0x2000; first inst_pc=0x2004.
//  5. rresp=2'b10 on beat 2 -> fetch_error=1, no further AR;
//     redirect to 0x3000 clears fetch_error and fetch resumes.
//  6. arready delayed 5 cycles -> araddr and arvalid held stable;
//     a redirect during the delay leads to DRAIN, then a fetch at the new PC.

Source files
------------

// File: rtl/axi_fetch_unit_if.sv
// AXI read address/data channels between the fetch unit (master) and the memory side (slave).
interface axi_fetch_unit_if #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_fetch_unit.sv
// Instruction fetch front end: line-sized AXI INCR bursts into an instruction FIFO feeding decode.
// Define FETCH_PERF_EN to add the perf_bursts_o / perf_insts_o / perf_stall_cycles_o counters.
module axi_fetch_unit #(
    parameter int unsigned ID_WIDTH    = 13,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BURST_BEATS = 8,
    parameter int unsigned FIFO_DEPTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] entry_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  fetch_error_o,
    axi_fetch_unit_if.master      m_axi
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]           perf_bursts_o,
    output logic [63:0]           perf_insts_o,
    output logic [63:0]           perf_stall_cycles_o
`endif
);
    localparam int unsigned LineBytes    = BURST_BEATS * DATA_WIDTH / 8;
    localparam int unsigned WordsPerLine = LineBytes / 4;
    localparam int unsigned WordsPerBeat = DATA_WIDTH / 32;
    localparam int unsigned OffBits      = $clog2(LineBytes);
    localparam int unsigned WordIdxW     = OffBits - 2;
    localparam int unsigned BeatW        = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW         = PtrW + 1;

    localparam logic [ADDR_WIDTH-1:0] LineMask    = ~ADDR_WIDTH'(LineBytes - 1);
    localparam logic [ADDR_WIDTH-1:0] WordMask    = ~ADDR_WIDTH'(3);
    localparam logic [CntW-1:0]       IssueThresh = CntW'(FIFO_DEPTH - WordsPerLine);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StDrain, StErr} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic                  err_pend_q, err_pend_d;
    logic                  redir_pend_q, redir_pend_d;
    logic                  fetch_error_q, fetch_error_d;

    logic [31:0]           inst_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    logic [WordIdxW-1:0]   word_idx  [WordsPerBeat];
    logic [PtrW-1:0]       push_slot [WordsPerBeat];
    logic [WordsPerBeat-1:0] push_en;
    logic [CntW-1:0]       n_push;
    logic [WordIdxW-1:0]   pc_woff;
    logic                  accept_data;
    logic                  pop;
    logic                  unused_rid;

    assign unused_rid = ^m_axi.rid;

    assign m_axi.arid    = ID_WIDTH'(0);
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = 8'(BURST_BEATS - 1);
    assign m_axi.arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = 3'b110;
    assign m_axi.arvalid = (state_q == StAddr);
    assign m_axi.rready  = (state_q == StData) || (state_q == StDrain);

    assign inst_valid_o  = (count_q != '0);
    assign inst_o        = inst_mem[rd_ptr_q];
    assign inst_pc_o     = pc_mem[rd_ptr_q];
    assign fetch_error_o = fetch_error_q;

    assign pc_woff     = pc_q[OffBits-1:2];
    assign accept_data = (state_q == StData) && m_axi.rvalid && !redirect_valid_i &&
                         (m_axi.rresp == 2'b00);
    assign pop         = inst_valid_o && inst_ready_i && !redirect_valid_i;

    // Words before the PC inside the line are dropped; the rest pack contiguously from wr_ptr.
    always_comb begin
        n_push = '0;
        for (int k = 0; k < WordsPerBeat; k++) begin
            word_idx[k]  = WordIdxW'(int'(beat_q) * WordsPerBeat + k);
            push_slot[k] = wr_ptr_q + n_push[PtrW-1:0];
            push_en[k]   = accept_data && (word_idx[k] >= pc_woff);
            if (push_en[k]) begin
                n_push = n_push + CntW'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        araddr_d      = araddr_q;
        beat_d        = beat_q;
        err_pend_d    = err_pend_q;
        redir_pend_d  = redir_pend_q;
        fetch_error_d = fetch_error_q;
        unique case (state_q)
            StIdle: begin
                if (!redirect_valid_i && (count_q <= IssueThresh)) begin
                    araddr_d = pc_q & LineMask;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                if (m_axi.arready) begin
                    beat_d       = '0;
                    redir_pend_d = 1'b0;
                    state_d      = (redir_pend_q || redirect_valid_i) ? StDrain : StData;
                end else if (redirect_valid_i) begin
                    redir_pend_d = 1'b1;
                end
            end
            StData: begin
                if (m_axi.rvalid) begin
                    beat_d = beat_q + BeatW'(1);
                    if (redirect_valid_i) begin
                        state_d = m_axi.rlast ? StIdle : StDrain;
                    end else if (m_axi.rresp != 2'b00) begin
                        fetch_error_d = 1'b1;
                        err_pend_d    = !m_axi.rlast;
                        state_d       = m_axi.rlast ? StErr : StDrain;
                    end else if (m_axi.rlast) begin
                        pc_d    = araddr_q + ADDR_WIDTH'(LineBytes);
                        state_d = StIdle;
                    end
                end else if (redirect_valid_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (m_axi.rvalid && m_axi.rlast) begin
                    state_d    = (err_pend_q && !redirect_valid_i) ? StErr : StIdle;
                    err_pend_d = 1'b0;
                end
            end
            StErr: begin
                if (redirect_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A redirect overrides PC and error status regardless of state.
        if (redirect_valid_i) begin
            pc_d          = redirect_pc_i & WordMask;
            fetch_error_d = 1'b0;
            err_pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            pc_q          <= entry_i & WordMask;
            araddr_q      <= '0;
            beat_q        <= '0;
            err_pend_q    <= 1'b0;
            redir_pend_q  <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            araddr_q      <= araddr_d;
            beat_q        <= beat_d;
            err_pend_q    <= err_pend_d;
            redir_pend_q  <= redir_pend_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || redirect_valid_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + n_push[PtrW-1:0];
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            count_q  <= count_q + n_push - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WordsPerBeat; k++) begin
            if (push_en[k]) begin
                inst_mem[push_slot[k]] <= m_axi.rdata[32*k +: 32];
                pc_mem[push_slot[k]]   <= araddr_q + ADDR_WIDTH'({word_idx[k], 2'b00});
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_bursts_o       <= '0;
            perf_insts_o        <= '0;
            perf_stall_cycles_o <= '0;
        end else begin
            perf_bursts_o       <= perf_bursts_o + 64'(m_axi.arvalid && m_axi.arready);
            perf_insts_o        <= perf_insts_o + 64'(inst_valid_o && inst_ready_i);
            perf_stall_cycles_o <= perf_stall_cycles_o + 64'(inst_ready_i && !inst_valid_o);
        end
    end
`endif
endmodule

// File: tb/tb_axi_fetch_unit.sv
// Self-checking bench for axi_fetch_unit: directed line-fetch table plus corner-case sequences.
module tb_axi_fetch_unit;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] entry_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        inst_valid;
    logic        inst_ready_i;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_error;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_bursts, perf_insts, perf_stall_cycles;
`endif

    axi_fetch_unit_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) axi_if ();

    axi_fetch_unit dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .entry_i          (entry_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .fetch_error_o    (fetch_error),
        .m_axi            (axi_if)
`ifdef FETCH_PERF_EN
        ,
        .perf_bursts_o       (perf_bursts),
        .perf_insts_o        (perf_insts),
        .perf_stall_cycles_o (perf_stall_cycles)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } rec_t;

    typedef struct {
        logic [63:0] entry;
        logic [63:0] araddr;
        logic [63:0] first_pc;
        int          n;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    rec_t        q[$];
    logic [63:0] ar_log[$];
    int          ar_delay = 0;
    int          err_beat = -1;
    int          beat = 0;
    bit          burst_active = 0;
    logic [63:0] burst_addr;
    bit          ar_fire = 0;
    bit          r_fire = 0;
    logic [63:0] fire_addr;
    int          ar_wait = 0;

    // Memory image: word at 0x1000 holds 0, next word 1, and so on.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'((a - 64'h1000) >> 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] entry);
        reset_i          = 1'b1;
        entry_i          = entry;
        redirect_valid_i = 1'b0;
        repeat (3) step();
        chk("rst_arvalid", 64'(axi_if.arvalid), 64'd0);
        chk("rst_rready", 64'(axi_if.rready), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_fetch_error", 64'(fetch_error), 64'd0);
        q.delete();
        ar_log.delete();
        reset_i = 1'b0;
    endtask

    // AXI slave: decisions on the falling edge, handshakes complete on the next rising edge.
    initial begin
        logic [63:0] d;
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rlast   = 1'b0;
        axi_if.rresp   = 2'b00;
        axi_if.rdata   = '0;
        axi_if.rid     = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                burst_active = 0;
                ar_wait      = 0;
            end else begin
                if (ar_fire) begin
                    ar_log.push_back(fire_addr);
                    burst_active = 1;
                    beat         = 0;
                    burst_addr   = fire_addr;
                    ar_wait      = 0;
                end
                if (r_fire) begin
                    beat++;
                    if (beat == 8) burst_active = 0;
                end
            end
            if (!reset_i && axi_if.arvalid && !burst_active) begin
                if (ar_wait >= ar_delay) axi_if.arready = 1'b1;
                else begin
                    axi_if.arready = 1'b0;
                    ar_wait++;
                end
            end else begin
                axi_if.arready = 1'b0;
                ar_wait        = 0;
            end
            if (burst_active) begin
                d[31:0]       = mem_word(burst_addr + 64'(8 * beat));
                d[63:32]      = mem_word(burst_addr + 64'(8 * beat + 4));
                axi_if.rdata  = d;
                axi_if.rvalid = 1'b1;
                axi_if.rlast  = (beat == 7);
                axi_if.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi_if.rvalid = 1'b0;
                axi_if.rlast  = 1'b0;
                axi_if.rresp  = 2'b00;
            end
            ar_fire   = !reset_i && axi_if.arvalid && axi_if.arready;
            fire_addr = axi_if.araddr;
            r_fire    = !reset_i && axi_if.rvalid && axi_if.rready;
        end
    end

    // Records every instruction decode takes at the coming rising edge.
    initial forever begin
        @(negedge clk_i);
        #2;
        if (!reset_i && !redirect_valid_i && inst_valid && inst_ready_i)
            q.push_back('{inst: inst, pc: inst_pc});
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   pre_n;
        bit   dropped_seen;

        vecs[0] = '{entry: 64'h1000, araddr: 64'h1000, first_pc: 64'h1000, n: 16};
        vecs[1] = '{entry: 64'h1008, araddr: 64'h1000, first_pc: 64'h1008, n: 14};
        vecs[2] = '{entry: 64'h103C, araddr: 64'h1000, first_pc: 64'h103C, n: 1};
        vecs[3] = '{entry: 64'h1006, araddr: 64'h1000, first_pc: 64'h1004, n: 15};
        vecs[4] = '{entry: 64'hFFFF_FFFF_FFFF_FFC4, araddr: 64'hFFFF_FFFF_FFFF_FFC0,
                    first_pc: 64'hFFFF_FFFF_FFFF_FFC4, n: 15};

        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        inst_ready_i     = 1'b1;
        reset_i          = 1'b1;
        entry_i          = 64'h1000;

        do_reset(64'h1000);
        chk("arlen", 64'(axi_if.arlen), 64'd7);
        chk("arsize", 64'(axi_if.arsize), 64'd3);
        chk("arburst", 64'(axi_if.arburst), 64'd1);
        chk("arprot", 64'(axi_if.arprot), 64'd6);
        chk("arcache_lock_id", 64'({axi_if.arcache, axi_if.arlock, axi_if.arid}), 64'd0);

        // Table: straight-line fetch from several entry points.
        foreach (vecs[v]) begin
            do_reset(vecs[v].entry);
            n = 0;
            while (!(ar_log.size() >= 2 && q.size() >= vecs[v].n) && n < 300) begin
                step();
                n++;
            end
            chk("vec_timeout", 64'(n < 300), 64'd1);
            chk("vec_araddr0", ar_log[0], vecs[v].araddr);
            chk("vec_araddr1", ar_log[1], vecs[v].araddr + 64'h40);
            for (int i = 0; i < vecs[v].n; i++) begin
                chk("vec_pc", q[i].pc, vecs[v].first_pc + 64'(4 * i));
                chk("vec_inst", 64'(q[i].inst), 64'(mem_word(vecs[v].first_pc + 64'(4 * i))));
            end
        end

        // Backpressure: two lines fill the FIFO, the third waits for 16 pops.
        inst_ready_i = 1'b0;
        do_reset(64'h1000);
        repeat (60) step();
        chk("bp_bursts", 64'(ar_log.size()), 64'd2);
        chk("bp_arvalid", 64'(axi_if.arvalid), 64'd0);
        chk("bp_valid", 64'(inst_valid), 64'd1);
        inst_ready_i = 1'b1;
        n = 0;
        while (q.size() < 15 && n < 100) begin
            step();
            n++;
        end
        inst_ready_i = 1'b0;
        repeat (10) step();
        chk("bp_pops15", 64'(q.size()), 64'd15);
        chk("bp_hold_bursts", 64'(ar_log.size()), 64'd2);
        chk("bp_hold_arvalid", 64'(axi_if.arvalid), 64'd0);
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        repeat (5) step();
        chk("bp_resume_bursts", 64'(ar_log.size()), 64'd3);
        chk("bp_resume_addr", ar_log[2], 64'h1080);
        chk("bp_pc15", q[15].pc, 64'h103C);

        // Redirect while beat 3 is on the bus.
        inst_ready_i = 1'b1;
        do_reset(64'h1000);
        n = 0;
        while (!(axi_if.rvalid && beat == 3 && ar_log.size() == 1) && n < 100) begin
            step();
            n++;
        end
        chk("rd_reach_beat3", 64'(n < 100), 64'd1);
        pre_n            = q.size();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h2004;
        step();
        redirect_valid_i = 1'b0;
        chk("rd_flush_valid", 64'(inst_valid), 64'd0);
        n = 0;
        while (!(ar_log.size() >= 2 && q.size() >= pre_n + 15) && n < 300) begin
            step();
            n++;
        end
        chk("rd_timeout", 64'(n < 300), 64'd1);
        chk("rd_araddr", ar_log[1], 64'h2000);
        chk("rd_first_pc", q[pre_n].pc, 64'h2004);
        chk("rd_first_inst", 64'(q[pre_n].inst), 64'(mem_word(64'h2004)));
        dropped_seen = 0;
        foreach (q[i]) if (q[i].pc >= 64'h1018 && q[i].pc <= 64'h103C) dropped_seen = 1;
        chk("rd_dropped_beats", 64'(dropped_seen), 64'd0);

        // Read error on beat 2, then recovery through a redirect.
        err_beat = 2;
        do_reset(64'h1000);
        n = 0;
        while (!fetch_error && n < 60) begin
            step();
            n++;
        end
        chk("err_timeout", 64'(n < 60), 64'd1);
        repeat (30) step();
        chk("err_sticky", 64'(fetch_error), 64'd1);
        chk("err_no_more_ar", 64'(ar_log.size()), 64'd1);
        chk("err_arvalid", 64'(axi_if.arvalid), 64'd0);
        chk("err_kept_words", 64'(q.size()), 64'd4);
        chk("err_last_pc", q[3].pc, 64'h100C);
        err_beat         = -1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h3000;
        step();
        redirect_valid_i = 1'b0;
        chk("err_cleared", 64'(fetch_error), 64'd0);
        n = 0;
        while (!(ar_log.size() >= 2 && q.size() >= 20) && n < 300) begin
            step();
            n++;
        end
        chk("err_resume_timeout", 64'(n < 300), 64'd1);
        chk("err_resume_addr", ar_log[1], 64'h3000);
        chk("err_resume_pc", q[4].pc, 64'h3000);
        chk("err_resume_inst", 64'(q[4].inst), 64'(mem_word(64'h3000)));
        chk("err_resume_last", q[19].pc, 64'h303C);

        // Slow arready with a redirect during the wait.
        ar_delay = 5;
        do_reset(64'h1000);
        n = 0;
        while (!axi_if.arvalid && n < 20) begin
            step();
            n++;
        end
        chk("dly_arvalid_seen", 64'(axi_if.arvalid), 64'd1);
        n = 0;
        while (ar_log.size() == 0 && n < 20) begin
            chk("dly_arvalid_hold", 64'(axi_if.arvalid), 64'd1);
            chk("dly_araddr_hold", axi_if.araddr, 64'h1000);
            redirect_valid_i = (n == 2);
            redirect_pc_i    = 64'h4008;
            step();
            n++;
        end
        redirect_valid_i = 1'b0;
        ar_delay         = 0;
        chk("dly_wait_len", 64'(n >= 5 && n < 20), 64'd1);
        n = 0;
        while (!(ar_log.size() >= 2 && q.size() >= 14) && n < 300) begin
            step();
            n++;
        end
        chk("dly_timeout", 64'(n < 300), 64'd1);
        chk("dly_araddr0", ar_log[0], 64'h1000);
        chk("dly_araddr1", ar_log[1], 64'h4000);
        chk("dly_first_pc", q[0].pc, 64'h4008);
        chk("dly_first_inst", 64'(q[0].inst), 64'(mem_word(64'h4008)));
`ifdef FETCH_PERF_EN
        chk("perf_bursts", perf_bursts, 64'(ar_log.size()));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
